// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_pkg
// Description : Shared helpers for the multi-channel button debouncer:
//               ceil-log2, sample-tick period and parameter legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef BUTTON_DEBOUNCE_PKG_SV
`define BUTTON_DEBOUNCE_PKG_SV

package button_debounce_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Clock cycles between consecutive sample ticks.
    function automatic int tick_cycles(input int clk_frequency,
                                       input int debounce_hz,
                                       input int samples);
        if ((debounce_hz * samples) <= 0)
            return 0;
        return clk_frequency / (debounce_hz * samples);
    endfunction

endpackage

`define BUTTON_DEBOUNCE_CHECK_PARAMS(CHANS, TICKS, SAMP, SYNC, HOLD) \
    if ((CHANS) < 1 || (TICKS) < 1 || (SAMP) < 2 || (SYNC) < 2 || (HOLD) < 0) begin : g_param_error \
        $error("button_debounce_multi: illegal parameter combination"); \
    end

`endif
`default_nettype wire

// File: rtl/button_debounce_tick.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_tick
// Description : Free-running prescaler producing a one-cycle sample tick
//               every TICK_CYCLES clocks, shared by all debounce channels.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_tick
    import button_debounce_pkg::*;
#(
    parameter int TICK_CYCLES = 25
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int c_COUNT_WIDTH = (clog2(TICK_CYCLES) > 0) ? clog2(TICK_CYCLES) : 1;
    localparam logic [c_COUNT_WIDTH-1:0] c_LAST = c_COUNT_WIDTH'(TICK_CYCLES - 1);

    logic [c_COUNT_WIDTH-1:0] r_count;
    logic [c_COUNT_WIDTH-1:0] w_count_next;
    logic                     w_tick;

    always_comb begin
        w_tick       = (r_count == c_LAST);
        w_count_next = w_tick ? '0 : r_count + c_COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/button_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_multi
// Description : N-channel button debouncer with shared sample tick,
//               selectable polarity, press/release and long-press pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_multi
    import button_debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CLK_FREQUENCY = 10_000_000,
    parameter int DEBOUNCE_HZ   = 2,
    parameter int SAMPLES       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0,
    parameter int HOLD_SAMPLES  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] debounce,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam int   c_TICK_CYCLES = tick_cycles(CLK_FREQUENCY, DEBOUNCE_HZ, SAMPLES);
    localparam int   c_CNT_WIDTH   = clog2(SAMPLES);
    localparam logic [c_CNT_WIDTH-1:0] c_CNT_LAST = c_CNT_WIDTH'(SAMPLES - 1);
    localparam logic c_INVERT      = (ACTIVE_LOW != 0);

    `BUTTON_DEBOUNCE_CHECK_PARAMS(CHANNELS, c_TICK_CYCLES, SAMPLES, SYNC_STAGES, HOLD_SAMPLES)

    logic w_tick;

    button_debounce_tick #(
        .TICK_CYCLES (c_TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_CNT_WIDTH-1:0] r_cnt;
            logic [c_CNT_WIDTH-1:0] w_cnt_next;
            logic                   r_debounce;
            logic                   r_press;
            logic                   r_release;
            logic                   w_sample;
            logic                   w_toggle;

            // Any sample agreeing with the current level restarts the window.
            always_comb begin
                w_sample   = r_sync[SYNC_STAGES-1] ^ c_INVERT;
                w_toggle   = 1'b0;
                w_cnt_next = r_cnt;
                if (w_sample == r_debounce) begin
                    w_cnt_next = '0;
                end else if (w_tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_toggle   = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync     <= '0;
                    r_cnt      <= '0;
                    r_debounce <= 1'b0;
                    r_press    <= 1'b0;
                    r_release  <= 1'b0;
                end else begin
                    r_sync     <= {r_sync[SYNC_STAGES-2:0], button[gi]};
                    r_cnt      <= w_cnt_next;
                    r_debounce <= r_debounce ^ w_toggle;
                    r_press    <= w_toggle & ~r_debounce;
                    r_release  <= w_toggle & r_debounce;
                end
            end

            assign debounce[gi]      = r_debounce;
            assign press[gi]         = r_press;
            assign release_pulse[gi] = r_release;

            if (HOLD_SAMPLES > 0) begin : g_hold
                localparam int c_HOLD_WIDTH = clog2(HOLD_SAMPLES + 1);
                localparam logic [c_HOLD_WIDTH-1:0] c_HOLD_MAX = c_HOLD_WIDTH'(HOLD_SAMPLES);

                logic [c_HOLD_WIDTH-1:0] r_hold;
                logic [c_HOLD_WIDTH-1:0] w_hold_next;
                logic                    r_long;
                logic                    w_long_next;

                // Saturation at the limit makes the pulse fire once per press.
                always_comb begin
                    w_hold_next = r_hold;
                    w_long_next = 1'b0;
                    if (!r_debounce) begin
                        w_hold_next = '0;
                    end else if (w_tick && (r_hold != c_HOLD_MAX)) begin
                        w_hold_next = r_hold + c_HOLD_WIDTH'(1);
                        w_long_next = (w_hold_next == c_HOLD_MAX);
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_hold <= '0;
                        r_long <= 1'b0;
                    end else begin
                        r_hold <= w_hold_next;
                        r_long <= w_long_next;
                    end
                end

                assign long_press[gi] = r_long;
            end else begin : g_no_hold
                assign long_press[gi] = 1'b0;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce_multi
// Description : Scoreboard bench for button_debounce_multi: an active-high
//               and an active-low instance, expected pulses queued with windows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce_multi;

    localparam int c_TICK     = 25;
    localparam int c_LAT_MIN  = 78;
    localparam int c_LAT_MAX  = 102;
    localparam int c_LONG_MIN = 176;
    localparam int c_LONG_MAX = 200;
    localparam int c_SETTLE   = 110;
    localparam int c_PRESS    = 0;
    localparam int c_RELEASE  = 1;
    localparam int c_LONG     = 2;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [1:0] button_a;
    logic [1:0] button_b;
    logic [1:0] deb_a, press_a, rel_a, long_a;
    logic [1:0] deb_b, press_b, rel_b, long_b;

    always #5 clk = ~clk;

    button_debounce_multi #(
        .CHANNELS(2), .CLK_FREQUENCY(1000), .DEBOUNCE_HZ(10), .SAMPLES(4),
        .SYNC_STAGES(2), .ACTIVE_LOW(0), .HOLD_SAMPLES(8)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .button(button_a), .debounce(deb_a),
        .press(press_a), .release_pulse(rel_a), .long_press(long_a)
    );

    button_debounce_multi #(
        .CHANNELS(2), .CLK_FREQUENCY(1000), .DEBOUNCE_HZ(10), .SAMPLES(4),
        .SYNC_STAGES(2), .ACTIVE_LOW(1), .HOLD_SAMPLES(8)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .button(button_b), .debounce(deb_b),
        .press(press_b), .release_pulse(rel_b), .long_press(long_b)
    );

    typedef struct {
        int dut;
        int kind;
        int ch;
        int base;
        bit rel;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   cyc          = 0;
    int   checks       = 0;
    int   errors       = 0;
    int   last_evt_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            c_PRESS:   return "press";
            c_RELEASE: return "release";
            default:   return "long_press";
        endcase
    endfunction

    function automatic logic get_pulse(input int d, input int k, input int ch);
        logic [1:0] v;
        if (d == 0) begin
            case (k)
                c_PRESS:   v = press_a;
                c_RELEASE: v = rel_a;
                default:   v = long_a;
            endcase
        end else begin
            case (k)
                c_PRESS:   v = press_b;
                c_RELEASE: v = rel_b;
                default:   v = long_b;
            endcase
        end
        return v[ch];
    endfunction

    // rel=1 measures latency from the previously matched event's cycle.
    task automatic expect_evt(input int d, input int k, input int ch,
                              input int base, input bit rel, input int lo, input int hi);
        exp_t e;
        e.dut = d; e.kind = k; e.ch = ch; e.base = base; e.rel = rel; e.lo = lo; e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int d, input int k, input int ch);
        exp_t e;
        int   base;
        int   lat;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got dut=%0d ch=%0d %s at cycle %0d, required no event",
                     d, ch, kind_name(k), cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.dut != d || e.ch != ch || e.kind != k) begin
            errors++;
            $display("FAIL event_identity got dut=%0d ch=%0d %s, required dut=%0d ch=%0d %s",
                     d, ch, kind_name(k), e.dut, e.ch, kind_name(e.kind));
        end
        base = e.rel ? last_evt_cyc : e.base;
        lat  = cyc - base;
        checks++;
        if (lat < e.lo || lat > e.hi) begin
            errors++;
            $display("FAIL event_latency dut=%0d ch=%0d %s got %0d cycles, required %0d..%0d",
                     d, ch, kind_name(k), lat, e.lo, e.hi);
        end
        last_evt_cyc = cyc;
    endtask

    // Monitor: every pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++)
                for (int k = 0; k < 3; k++)
                    if (get_pulse(d, k, ch)) check_event(d, k, ch);
        checks++;
        if (((press_a & rel_a) | (press_a & long_a) | (press_b & rel_b) | (press_b & long_b)) != 2'b00) begin
            errors++;
            $display("FAIL pulse_overlap got a=%b/%b/%b b=%b/%b/%b, required no coincident pulses",
                     press_a, rel_a, long_a, press_b, rel_b, long_b);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got %0d pending events, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int c;
        int r_a;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        button_a = 2'b00;
        button_b = 2'b11;
        repeat (3) @(negedge clk);
        check_val("reset_a", {deb_a, press_a, rel_a, long_a}, 8'h00);
        check_val("reset_b", {deb_b, press_b, rel_b, long_b}, 8'h00);
        rst_a = 1'b0;
        rst_b = 1'b0;
        r_a   = cyc;

        // Clean press on ch0, long press, long hold and a short low glitch.
        wait_cyc(5);
        button_a[0] = 1'b1;
        c = cyc;
        expect_evt(0, c_PRESS, 0, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        expect_evt(0, c_LONG,  0, 0, 1'b1, c_LONG_MIN, c_LONG_MAX);
        wait_cyc(c_SETTLE);
        check_val("t1_level_a", {6'b0, deb_a}, 8'h01);
        check_val("t5_idle_b",  {6'b0, deb_b}, 8'h00);
        wait_cyc(320 - c_SETTLE);
        check_drained("t3_long");
        wait_cyc(1000);
        button_a[0] = 1'b0;
        wait_cyc(30);
        button_a[0] = 1'b1;
        wait_cyc(100);
        check_val("t3_glitch_level", {6'b0, deb_a}, 8'h01);

        // Press ch1, then release both channels together.
        button_a[1] = 1'b1;
        c = cyc;
        expect_evt(0, c_PRESS, 1, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        wait_cyc(c_SETTLE);
        check_drained("t4_press1");
        check_val("t4_both_level", {6'b0, deb_a}, 8'h03);
        button_a = 2'b00;
        c = cyc;
        expect_evt(0, c_RELEASE, 0, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        expect_evt(0, c_RELEASE, 1, 0, 1'b1, 0, 0);
        wait_cyc(c_SETTLE);
        check_drained("t4_release");
        check_val("t4_released_level", {6'b0, deb_a}, 8'h00);

        // Bounce on ch0: toggle every 3 cycles for 60 cycles, then settle high.
        for (int i = 0; i < 20; i++) begin
            button_a[0] = ~button_a[0];
            wait_cyc(3);
        end
        button_a[0] = 1'b1;
        c = cyc;
        expect_evt(0, c_PRESS, 0, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        wait_cyc(c_SETTLE);
        check_drained("t2_bounce");
        check_val("t2_level", {6'b0, deb_a}, 8'h01);
        button_a[0] = 1'b0;
        c = cyc;
        expect_evt(0, c_RELEASE, 0, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        wait_cyc(c_SETTLE);
        check_drained("t2_release");

        // Active-low instance: raw 0 means pressed.
        button_b[0] = 1'b0;
        c = cyc;
        expect_evt(1, c_PRESS, 0, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        wait_cyc(c_SETTLE);
        check_drained("t5_press");
        check_val("t5_level_b", {6'b0, deb_b}, 8'h01);
        button_b[0] = 1'b1;
        c = cyc;
        expect_evt(1, c_RELEASE, 0, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        wait_cyc(c_SETTLE);
        check_drained("t5_release");
        check_val("t5_released_b", {6'b0, deb_b}, 8'h00);

        // Reset mid-window: ch1 held pressed, ch0 counter at 2.
        button_a[1] = 1'b1;
        c = cyc;
        expect_evt(0, c_PRESS, 1, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        wait_cyc(c_SETTLE);
        check_drained("t6_press1");
        check_val("t6_pre_level", {6'b0, deb_a}, 8'h02);
        while (((cyc - r_a) % c_TICK) != 0) @(negedge clk);
        button_a[0] = 1'b1;
        wait_cyc(60);
        rst_a = 1'b1;
        @(negedge clk);
        check_val("t6_reset_outputs", {deb_a, press_a, rel_a, long_a}, 8'h00);
        rst_a = 1'b0;
        r_a   = cyc;
        expect_evt(0, c_PRESS, 0, r_a, 1'b0, c_LAT_MIN, c_LAT_MAX);
        expect_evt(0, c_PRESS, 1, 0, 1'b1, 0, 0);
        wait_cyc(c_SETTLE);
        check_drained("t6_repress");
        check_val("t6_level", {6'b0, deb_a}, 8'h03);
        button_a = 2'b00;
        c = cyc;
        expect_evt(0, c_RELEASE, 0, c, 1'b0, c_LAT_MIN, c_LAT_MAX);
        expect_evt(0, c_RELEASE, 1, 0, 1'b1, 0, 0);
        wait_cyc(c_SETTLE);
        check_drained("t6_release");

        wait_cyc(20);
        check_drained("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
